// File: rtl/tluh_32_pkg.sv
// Shared TL-UL (32-bit data) type definitions.
// Holds the A/D channel structs, bus widths and the opcode enums used by every
// TL-UL endpoint in this slice.
package tluh_32_pkg;

    localparam int unsigned TL_AIW  = 8;           // source id width
    localparam int unsigned TL_DW   = 32;          // data width
    localparam int unsigned TL_DBW  = TL_DW / 8;   // byte lanes
    localparam int unsigned TL_SZW  = 2;           // size field width

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    // Host to device: A channel request plus D channel ready.
    typedef struct packed {
        logic                a_valid;
        tl_a_op_e            a_opcode;
        logic [TL_SZW-1:0]   a_size;
        logic [TL_AIW-1:0]   a_source;
        logic [31:0]         a_address;
        logic [TL_DBW-1:0]   a_mask;
        logic [TL_DW-1:0]    a_data;
        logic                d_ready;
    } tl_h2d_t;

    // Device to host: D channel response plus A channel ready.
    typedef struct packed {
        logic                d_valid;
        tl_d_op_e            d_opcode;
        logic [2:0]          d_param;
        logic [TL_SZW-1:0]   d_size;
        logic [TL_AIW-1:0]   d_source;
        logic                d_sink;
        logic [TL_DW-1:0]    d_data;
        logic [3:0]          d_user;
        logic                d_error;
        logic                a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/tlul_adapter_reg_pkg.sv
// Local definitions for the TL-UL register adapter: response FSM states and
// a helper that returns the byte lanes a request of a given size may touch.
package tlul_adapter_reg_pkg;

    typedef enum logic {
        StIdle = 1'b0,
        StPend = 1'b1
    } adapter_state_e;

    // Byte lanes covered by a_size starting at byte offset addr_lo.
    // Sizes above a word return all lanes; such sizes are flagged elsewhere.
    function automatic logic [3:0] tl_size_lanes(input logic [1:0] size,
                                                 input logic [1:0] addr_lo);
        logic [3:0] lanes;
        case (size)
            2'd0:    lanes = 4'b0001 << addr_lo;
            2'd1:    lanes = 4'b0011 << {addr_lo[1], 1'b0};
            default: lanes = 4'b1111;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/tlul_req_chk.sv
// Combinational TL-UL A-channel request checker.
// Flags a request as erroneous on an illegal opcode, a non word-aligned
// address, a size above one word, a partial write (optional), an address
// beyond the register window (optional) or mask bits outside the lanes
// addressed by a_size/a_address.
// Ports:
//   a_opcode_i   in   request opcode
//   a_size_i     in   log2 of access size in bytes
//   a_address_i  in   full 32-bit byte address
//   a_mask_i     in   byte mask
//   err_o        out  request must be answered with d_error and no strobe
module tlul_req_chk
    import tluh_32_pkg::*;
    import tlul_adapter_reg_pkg::*;
#(
    parameter int unsigned RegAw           = 8,
    parameter bit          ErrOnPartialWr  = 1'b1,
    parameter bit          ErrOnOutOfRange = 1'b1
) (
    input  tl_a_op_e    a_opcode_i,
    input  logic [1:0]  a_size_i,
    input  logic [31:0] a_address_i,
    input  logic [3:0]  a_mask_i,
    output logic        err_o
);

    logic w_op_err;
    logic w_align_err;
    logic w_size_err;
    logic w_partial_err;
    logic w_range_err;
    logic w_mask_err;

    always_comb begin
        w_op_err = 1'b1;
        case (a_opcode_i)
            PutFullData, PutPartialData, Get: w_op_err = 1'b0;
            default:                          w_op_err = 1'b1;
        endcase
    end

    assign w_align_err   = (a_address_i[1:0] != 2'b00);
    assign w_size_err    = (a_size_i == 2'd3);
    assign w_partial_err = ErrOnPartialWr && (a_opcode_i == PutPartialData) &&
                           (a_mask_i != 4'hF);
    // Shift keeps only the bits above the register window.
    assign w_range_err   = ErrOnOutOfRange && ((a_address_i >> RegAw) != 32'h0);
    assign w_mask_err    = |(a_mask_i & ~tl_size_lanes(a_size_i, a_address_i[1:0]));

    assign err_o = w_op_err | w_align_err | w_size_err | w_partial_err |
                   w_range_err | w_mask_err;

endmodule

// File: rtl/tlul_adapter_reg.sv
// TL-UL device endpoint to single-cycle register strobe adapter.
// Accepts Get/PutFullData/PutPartialData from a socket device port, fires a
// one-cycle read or write strobe in the accept cycle and returns the
// AccessAck/AccessAckData one cycle later. One transaction may be pending;
// a new request is accepted in the same cycle the pending response is taken.
// Optional build macro: TLUL_ADAPTER_REG_BUSY_EN adds reg_busy_i, which holds
// off acceptance (and therefore all strobes) while the peripheral is busy.
// Ports:
//   clk_i        in   clock
//   rst_ni       in   asynchronous active-low reset
//   tl_i         in   TL-UL request from the socket
//   tl_o         out  TL-UL response to the socket
//   reg_re_o     out  read strobe
//   reg_we_o     out  write strobe
//   reg_addr_o   out  word-aligned register address
//   reg_wdata_o  out  write data
//   reg_be_o     out  byte enables
//   reg_rdata_i  in   read data, valid alongside reg_re_o
//   reg_error_i  in   peripheral error, sampled alongside a strobe
//   reg_busy_i   in   (TLUL_ADAPTER_REG_BUSY_EN only) peripheral busy
module tlul_adapter_reg
    import tluh_32_pkg::*;
    import tlul_adapter_reg_pkg::*;
#(
    parameter int unsigned RegAw           = 8,
    parameter bit          ErrOnPartialWr  = 1'b1,
    parameter bit          ErrOnOutOfRange = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  tl_h2d_t          tl_i,
    output tl_d2h_t          tl_o,
    output logic             reg_re_o,
    output logic             reg_we_o,
    output logic [RegAw-1:0] reg_addr_o,
    output logic [31:0]      reg_wdata_o,
    output logic [3:0]       reg_be_o,
    input  logic [31:0]      reg_rdata_i,
    input  logic             reg_error_i
`ifdef TLUL_ADAPTER_REG_BUSY_EN
    ,
    input  logic             reg_busy_i
`endif
);

    adapter_state_e r_state;
    adapter_state_e w_state_d;

    logic        w_busy;
    logic        w_pend;
    logic        w_a_ready;
    logic        w_accept;
    logic        w_rd;
    logic        w_wr;
    logic        w_err;
    logic        w_rsp_err;
    logic [31:0] w_rsp_data;

    tl_d_op_e    r_d_opcode;
    logic [1:0]  r_d_size;
    logic [7:0]  r_d_source;
    logic        r_d_error;
    logic [31:0] r_d_data;

`ifdef TLUL_ADAPTER_REG_BUSY_EN
    assign w_busy = reg_busy_i;
`else
    assign w_busy = 1'b0;
`endif

    tlul_req_chk #(
        .RegAw           (RegAw),
        .ErrOnPartialWr  (ErrOnPartialWr),
        .ErrOnOutOfRange (ErrOnOutOfRange)
    ) u_req_chk (
        .a_opcode_i  (tl_i.a_opcode),
        .a_size_i    (tl_i.a_size),
        .a_address_i (tl_i.a_address),
        .a_mask_i    (tl_i.a_mask),
        .err_o       (w_err)
    );

    assign w_pend = (r_state == StPend);
    // d_ready feeds a_ready combinationally so a response can retire and a
    // new request be accepted in the same cycle.
    assign w_a_ready = (~w_pend | tl_i.d_ready) & ~w_busy;
    assign w_accept  = tl_i.a_valid & w_a_ready;

    assign w_rd = (tl_i.a_opcode == Get);
    assign w_wr = (tl_i.a_opcode == PutFullData) | (tl_i.a_opcode == PutPartialData);

    assign reg_re_o    = w_accept & w_rd & ~w_err;
    assign reg_we_o    = w_accept & w_wr & ~w_err;
    assign reg_addr_o  = {tl_i.a_address[RegAw-1:2], 2'b00};
    assign reg_wdata_o = tl_i.a_data;
    assign reg_be_o    = tl_i.a_mask;

    assign w_rsp_err  = w_err | (reg_error_i & (reg_re_o | reg_we_o));
    // Read data is only returned for a read that completed without error.
    assign w_rsp_data = (reg_re_o & ~reg_error_i) ? reg_rdata_i : 32'h0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_state_d = StPend;
                end
            end
            StPend: begin
                if (w_accept) begin
                    w_state_d = StPend;
                end else if (tl_i.d_ready) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_d_opcode <= AccessAck;
            r_d_size   <= 2'd0;
            r_d_source <= 8'd0;
            r_d_error  <= 1'b0;
            r_d_data   <= 32'h0;
        end else if (w_accept) begin
            r_d_opcode <= w_rd ? AccessAckData : AccessAck;
            r_d_size   <= tl_i.a_size;
            r_d_source <= tl_i.a_source;
            r_d_error  <= w_rsp_err;
            r_d_data   <= w_rsp_data;
        end
    end

    always_comb begin
        tl_o          = '0;
        tl_o.d_valid  = w_pend;
        tl_o.d_opcode = r_d_opcode;
        tl_o.d_size   = r_d_size;
        tl_o.d_source = r_d_source;
        tl_o.d_data   = r_d_data;
        tl_o.d_error  = r_d_error;
        tl_o.a_ready  = w_a_ready;
    end

endmodule

// File: doc/tlul_adapter_reg.md
Name: tlul_adapter_reg

Overview:
- Device-side endpoint that sits directly downstream of one tlul_socket_1n device port (tl_d_o[i]/tl_d_i[i]).
- Converts TL-UL Get/PutFullData/PutPartialData into a single-cycle register-file strobe interface for a peripheral such as the SPI CSR block.
- Returns the matching AccessAck/AccessAckData with error checking.
- Supports one outstanding transaction, with full back-to-back throughput.

Parameters:
- RegAw, 8: register address width; reg_addr_o = a_address[RegAw-1:0] with bits [1:0] forced to 0.
- ErrOnPartialWr, 1: if 1, PutPartialData with a_mask != 4'hF is an error.
- ErrOnOutOfRange, 1: if 1, a_address[31:RegAw] != 0 is an error.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- tl_i  in  tluh_32_pkg::tl_h2d_t  TL-UL request from the socket device port
- tl_o  out  tluh_32_pkg::tl_d2h_t  TL-UL response to the socket device port
- reg_re_o  out  1  read strobe, one cycle per accepted Get
- reg_we_o  out  1  write strobe, one cycle per accepted Put
- reg_addr_o  out  RegAw  word-aligned register address
- reg_wdata_o  out  32  write data (a_data)
- reg_be_o  out  4  byte enables (a_mask)
- reg_rdata_i  in  32  read data, valid in the same cycle as reg_re_o
- reg_error_i  in  1  peripheral error, sampled in the same cycle as the strobe

Behaviour:
- Reset values: rsp_pend_q=0, d_valid=0; all response fields 0; strobes 0.
- Handshake:
  - a_ready = ~rsp_pend_q | tl_i.d_ready. This is a combinational d_ready -> a_ready path, which permits one transaction per cycle.
  - Accept = a_valid & a_ready.
- Request decode on accept:
  - rd = (opcode == Get); wr = (opcode == PutFull or PutPartial).
  - err_int is set by any of: illegal opcode; a_address[1:0] != 0; a_size > 2; ErrOnPartialWr violation; ErrOnOutOfRange violation; any a_mask bit set outside the lanes covered by a_size/a_address.
- Strobes: reg_re_o = accept & rd & ~err_int; reg_we_o = accept & wr & ~err_int. Both are combinational in the accept cycle, and a request with err_int produces no strobe.
- Response capture (registered on accept):
  - rsp_pend_q <= 1.
  - d_opcode <= AccessAckData for Get, AccessAck otherwise (illegal opcodes get AccessAck).
  - d_size/d_source <= a_size/a_source.
  - d_error <= err_int | reg_error_i & (re|we).
  - d_data <= reg_rdata_i if the read is error-free, otherwise 0.
  - d_param/d_sink/d_user are always 0.
- Latency: d_valid asserts the cycle after accept and is held stable until d_ready.
- Pend update: if d_valid & d_ready and no new accept, rsp_pend_q <= 0. If response-taken and a new accept occur in the same cycle, pend stays 1 and the response registers load the new transaction.
- Boundaries:
  - With d_ready held low, a_ready=0 and a second request stalls; no strobe fires.
  - An async reset mid-response drops d_valid immediately, and the pending response is discarded.
  - Once asserted, d_valid is not retracted except by reset.

Optional Feature:
- Macro: TLUL_ADAPTER_REG_BUSY_EN.
- With it: an additional input port reg_busy_i (1 bit). a_ready is additionally gated by ~reg_busy_i, and strobes never fire while busy. This lets a slow peripheral (SPI FIFO pointer update) stall acceptance.
- Without it: no port; the peripheral is always ready.

Decomposition:
- tluh_32_pkg (shared) holds tl_h2d_t/tl_d2h_t, TL_AIW/TL_DW, and the opcode enums (tl_a_op_e: PutFullData=0, PutPartialData=1, Get=4; tl_d_op_e: AccessAck=0, AccessAckData=1).
- One sub-module is natural: tlul_req_chk, a combinational err_int generator, which can be reused by tlul_err_resp.
- The response register and pend FSM (IDLE/PEND) stay in the top module.

Test Plan:
- Get addr 0x08, reg_rdata_i=0xDEADBEEF, d_ready=1 -> reg_re_o=1 and reg_addr_o=0x08 in the accept cycle; next cycle d_valid=1, AccessAckData, d_data=0xDEADBEEF, d_error=0, source echoed.
- PutFull addr 0x04, data 0x12345678, mask 0xF -> reg_we_o=1, wdata=0x12345678, be=0xF; response AccessAck, d_error=0, d_data=0.
- PutPartial mask 0x3 with ErrOnPartialWr=1 -> no reg_we_o; AccessAck with d_error=1. Get addr 0x102 (misaligned) -> no strobe; AccessAckData, d_error=1, d_data=0.
- d_ready low for 5 cycles after a Get -> d_valid and fields stable, a_ready=0, second Put waiting with no strobe; when d_ready rises, the Put is accepted in the same cycle and its AccessAck appears the next cycle.
- Back-to-back 4 Gets with d_ready=1 -> 4 reg_re_o pulses on consecutive cycles and 4 responses on consecutive cycles, in order.
- Assert rst_ni=0 while d_valid=1 -> d_valid=0 asynchronously; after release a_ready=1 and there is no stale response. With TLUL_ADAPTER_REG_BUSY_EN, holding reg_busy_i=1 forces a_ready=0.
